// File: rtl/tank_level_emulator.sv
// Reservoir plant model: integrates Ve/Vs/Bs valve commands into a level
// and drives thermometer-coded H/M/L sensors with optional fault override.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   Ve, Vs, Bs      inlet / drip / sprinkler valve commands
//   fault[1:0]      00 none, 01 M=1/L=0, 10 H=1/M=0, 11 all sensors 0
//   ovf_ack         clears sticky overflow/underflow
//   H, M, L         registered level sensors
//   level           simulated level
//   tick            one-cycle pulse per integration tick
//   overflow        sticky: fill clipped at LEVEL_MAX
//   underflow       sticky: drain clipped at 0
module tank_level_emulator #(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 255,
  parameter int RESET_LEVEL = 0,
  parameter int TICK_DIV    = 50000,
  parameter int FILL_STEP   = 4,
  parameter int DRIP_STEP   = 1,
  parameter int SPRAY_STEP  = 3,
  parameter int L_TH        = 16,
  parameter int M_TH        = 96,
  parameter int H_TH        = 192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Ve,
  input  logic               Vs,
  input  logic               Bs,
  input  logic [1:0]         fault,
  input  logic               ovf_ack,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               underflow
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW    = LEVEL_W + 2;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(TICK_DIV - 1);
  localparam logic signed [SW-1:0] MAX_S =
    SW'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] MAX_L =
    LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] RST_LVL =
    LEVEL_W'(RESET_LEVEL);
  localparam logic [2:0] RST_HML = {
    1'(RESET_LEVEL >= H_TH),
    1'(RESET_LEVEL >= M_TH),
    1'(RESET_LEVEL >= L_TH)
  };

  logic [DIV_W-1:0]         div;
  logic                     wrap;
  logic signed [SW-1:0]     fill_d;
  logic signed [SW-1:0]     drip_d;
  logic signed [SW-1:0]     spray_d;
  logic signed [SW-1:0]     delta;
  logic signed [SW-1:0]     sum;
  logic                     clamp_hi;
  logic                     clamp_lo;
  logic [LEVEL_W-1:0]       next_level;
  logic [2:0]               hml_d;

  assign wrap = (div == DIV_LAST);

  // Valves contribute independently; all three open just sum.
  always_comb begin
    fill_d  = Ve ? SW'(FILL_STEP)  : '0;
    drip_d  = Vs ? SW'(DRIP_STEP)  : '0;
    spray_d = Bs ? SW'(SPRAY_STEP) : '0;
    delta   = fill_d - drip_d - spray_d;
    sum     = $signed({2'b00, level}) + delta;
  end

  // Exact landing on 0 or LEVEL_MAX is not a clamp.
  assign clamp_hi = (sum > MAX_S);
  assign clamp_lo = sum[SW-1];

  always_comb begin
    next_level = sum[LEVEL_W-1:0];
    if (clamp_hi)
      next_level = MAX_L;
    else if (clamp_lo)
      next_level = '0;
  end

  // Threshold decode of the current level, then fault override.
  always_comb begin
    hml_d = {
      level >= LEVEL_W'(H_TH),
      level >= LEVEL_W'(M_TH),
      level >= LEVEL_W'(L_TH)
    };
    unique case (fault)
      2'b00: ;
      2'b01: hml_d[1:0] = 2'b10;
      2'b10: hml_d[2:1] = 2'b10;
      2'b11: hml_d      = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      tick      <= 1'b0;
      level     <= RST_LVL;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      {H, M, L} <= RST_HML;
    end else begin
      tick <= wrap;
      div  <= wrap ? '0 : div + DIV_W'(1);
      if (wrap)
        level <= next_level;
      // A new clamp beats a simultaneous acknowledge.
      if (wrap && clamp_hi)
        overflow <= 1'b1;
      else if (ovf_ack)
        overflow <= 1'b0;
      if (wrap && clamp_lo)
        underflow <= 1'b1;
      else if (ovf_ack)
        underflow <= 1'b0;
      {H, M, L} <= hml_d;
    end
  end

endmodule
